// File: rtl/quadratic_datapath.sv
// quadratic_datapath: three-stage elastic valid/ready pipeline computing y = A*x^2 + C mod 2^WIDTH_DATA.
// Define QUADRATIC_LINEAR_TERM_EN to add the B*x term (same latency and handshake).
module quadratic_datapath #(
  parameter int unsigned WIDTH_DATA = 16,
  parameter logic [WIDTH_DATA-1:0] A = WIDTH_DATA'(101),
  parameter logic [WIDTH_DATA-1:0] B = WIDTH_DATA'(59),
  parameter logic [WIDTH_DATA-1:0] C = WIDTH_DATA'(76)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_DATA-1:0] i_x,
  input  logic                  i_valid_in,
  output logic                  i_ready_out,
  output logic [WIDTH_DATA-1:0] o_y,
  output logic                  o_valid_out,
  input  logic                  o_ready_in
);

  logic                  r_v1, r_v2, r_v3;
  logic [WIDTH_DATA-1:0] r_x1, r_xx2, r_y3;
  logic                  w_ld1, w_ld2, w_ld3;
  logic [WIDTH_DATA-1:0] w_xx, w_y;

  // A stage may load when it is empty or its content leaves this cycle.
  assign w_ld3       = !r_v3 || o_ready_in;
  assign w_ld2       = !r_v2 || w_ld3;
  assign w_ld1       = !r_v1 || w_ld2;
  assign i_ready_out = rst && w_ld1;

  assign w_xx = r_x1 * r_x1;

`ifdef QUADRATIC_LINEAR_TERM_EN
  logic [WIDTH_DATA-1:0] r_x2;
  logic [WIDTH_DATA-1:0] w_bx;

  assign w_bx = B * r_x2;
  assign w_y  = A * r_xx2 + w_bx + C;
`else
  assign w_y  = A * r_xx2 + C;

  // B has no effect without the linear term; this block generates nothing.
  if (B != {WIDTH_DATA{1'b0}}) begin : g_b_ignored
  end
`endif

  // Valid bits and the output register; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_y3 <= {WIDTH_DATA{1'b0}};
    end else begin
      if (w_ld1) begin
        r_v1 <= i_valid_in;
      end
      if (w_ld2) begin
        r_v2 <= r_v1;
      end
      if (w_ld3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_y3 <= w_y;
        end
      end
    end
  end

  // Operand and square registers only move with a valid item.
  always_ff @(posedge clk) begin
    if (w_ld1 && i_valid_in) begin
      r_x1 <= i_x;
    end
    if (w_ld2 && r_v1) begin
      r_xx2 <= w_xx;
`ifdef QUADRATIC_LINEAR_TERM_EN
      r_x2  <= r_x1;
`endif
    end
  end

  assign o_y         = r_y3;
  assign o_valid_out = r_v3;

endmodule

// File: tb/tb_quadratic_datapath.sv
// tb_quadratic_datapath: directed table, backpressure, reset and random soak checks for quadratic_datapath.
// Expected values follow the QUADRATIC_LINEAR_TERM_EN setting of the build.
module tb_quadratic_datapath;

  localparam logic [15:0]  A16 = 16'd101;
  localparam logic [15:0]  B16 = 16'd59;
  localparam logic [15:0]  C16 = 16'd76;
  localparam logic [399:0] AS  = 400'd101;
  localparam logic [399:0] BS  = 400'd59;
  localparam logic [399:0] CS  = 400'd76;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [15:0]  x16, y16;
  logic         v16_in, r16_out, v16_out, r16_in;
  logic [399:0] xs, ys;
  logic         vs_in, rs_out, vs_out, rs_in;

  int n_cmp = 0;
  int n_bad = 0;

  quadratic_datapath #(.WIDTH_DATA(16)) u_dut16 (
    .clk(clk), .rst(rst), .i_x(x16), .i_valid_in(v16_in), .i_ready_out(r16_out),
    .o_y(y16), .o_valid_out(v16_out), .o_ready_in(r16_in)
  );

  quadratic_datapath #(.WIDTH_DATA(400)) u_dut400 (
    .clk(clk), .rst(rst), .i_x(xs), .i_valid_in(vs_in), .i_ready_out(rs_out),
    .o_y(ys), .o_valid_out(vs_out), .o_ready_in(rs_in)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;
  vec_t vecs[7];

  logic [15:0]  q16[$];
  logic [399:0] qs[$];
  int cyc16, acc16, out16, first_acc, first_out, last_out;
  int accs, outs;

  function automatic logic [15:0] f16(input logic [15:0] x);
    logic [15:0] y;
    y = A16 * x * x + C16;
`ifdef QUADRATIC_LINEAR_TERM_EN
    y = y + B16 * x;
`endif
    return y;
  endfunction

  function automatic logic [399:0] fs(input logic [399:0] x);
    logic [399:0] y;
    y = AS * x * x + CS;
`ifdef QUADRATIC_LINEAR_TERM_EN
    y = y + BS * x;
`endif
    return y;
  endfunction

  function automatic logic [399:0] rand400();
    logic [399:0] r;
    r = 400'd0;
    for (int k = 0; k < 13; k++) r = (r << 32) | 400'($urandom());
    return r;
  endfunction

  task automatic checkv(input string name, input logic [399:0] act, input logic [399:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of the 16-bit DUT: sample handshakes at negedge, update scoreboard.
  task automatic tick16(input logic [15:0] e, output logic acc);
    logic ao;
    logic [15:0] yy;
    @(negedge clk);
    acc = v16_in && r16_out;
    ao  = v16_out && r16_in;
    yy  = y16;
    if (acc) begin
      q16.push_back(e);
      acc16++;
      if (first_acc < 0) first_acc = cyc16;
    end
    if (ao) begin
      out16++;
      if (first_out < 0) first_out = cyc16;
      last_out = cyc16;
      if (q16.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out16: got y=%0d with nothing outstanding", yy);
      end else begin
        checkv("y16", 400'(yy), 400'(q16.pop_front()));
      end
    end
    cyc16++;
    @(posedge clk);
    #1;
  endtask

  task automatic tick400(output logic acc);
    logic ao;
    logic [399:0] yy;
    @(negedge clk);
    acc = vs_in && rs_out;
    ao  = vs_out && rs_in;
    yy  = ys;
    if (acc) begin
      qs.push_back(fs(xs));
      accs++;
    end
    if (ao) begin
      outs++;
      if (qs.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_out400: got y=%0d with nothing outstanding", yy);
      end else begin
        checkv("y400", yy, qs.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_counts();
    cyc16 = 0; acc16 = 0; out16 = 0;
    first_acc = -1; first_out = -1; last_out = -1;
  endtask

  task automatic drain16(input string name);
    logic a;
    v16_in = 1'b0;
    r16_in = 1'b1;
    for (int k = 0; k < 30 && q16.size() > 0; k++) tick16(16'd0, a);
    checki(name, q16.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int   bp_acc;
    int   sent;
    int   budget;

`ifdef QUADRATIC_LINEAR_TERM_EN
    vecs[0] = '{16'd0,     16'd76};
    vecs[1] = '{16'd1,     16'd236};
    vecs[2] = '{16'd2,     16'd598};
    vecs[3] = '{16'd3,     16'd1162};
    vecs[4] = '{16'd65535, 16'd118};
    vecs[5] = '{16'd256,   16'd15180};
    vecs[6] = '{16'd255,   16'd29046};
`else
    vecs[0] = '{16'd0,     16'd76};
    vecs[1] = '{16'd1,     16'd177};
    vecs[2] = '{16'd2,     16'd480};
    vecs[3] = '{16'd3,     16'd985};
    vecs[4] = '{16'd65535, 16'd177};
    vecs[5] = '{16'd256,   16'd76};
    vecs[6] = '{16'd255,   16'd14001};
`endif

    rst = 1'b0;
    x16 = 16'd0; v16_in = 1'b0; r16_in = 1'b1;
    xs = 400'd0; vs_in = 1'b0; rs_in = 1'b0;
    reset_counts();
    #12;
    checki("rst_valid16", int'(v16_out), 0);
    checkv("rst_y16", 400'(y16), 400'd0);
    checki("rst_ready16", int'(r16_out), 0);
    checki("rst_valid400", int'(vs_out), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checki("ready_after_rst", int'(r16_out), 1);

    // Table: back-to-back with the consumer always ready.
    reset_counts();
    for (int i = 0; i < 7; i++) begin
      x16 = vecs[i].x;
      v16_in = 1'b1;
      tick16(vecs[i].y, a);
    end
    drain16("table_drain");
    checki("table_accepted", acc16, 7);
    checki("table_emitted", out16, 7);
    checki("latency", first_out - first_acc, 3);
    checki("no_gaps", last_out - first_out, 6);

    // Backpressure: consumer stalled, producer keeps offering 1, 2, 3, ...
    reset_counts();
    r16_in = 1'b0;
    bp_acc = 1;
    for (int k = 0; k < 6; k++) begin
      x16 = 16'(bp_acc);
      v16_in = 1'b1;
      tick16(f16(x16), a);
      if (a) bp_acc++;
      if (v16_out) checkv("bp_hold_y", 400'(y16), 400'(f16(16'd1)));
    end
    checki("bp_accepted", acc16, 3);
    checki("bp_ready_low", int'(r16_out), 0);
    checki("bp_valid_high", int'(v16_out), 1);
    r16_in = 1'b1;
    x16 = 16'(bp_acc);
    tick16(f16(x16), a);
    checki("bp_resume_accept", int'(a), 1);
    v16_in = 1'b0;
    for (int k = 0; k < 3; k++) tick16(16'd0, a);
    checki("bp_burst_outputs", out16, 4);
    drain16("bp_drain");

    // Reset with two items in flight, one of them already presented.
    reset_counts();
    x16 = 16'd5; v16_in = 1'b1; tick16(f16(x16), a);
    x16 = 16'd6; tick16(f16(x16), a);
    v16_in = 1'b0; r16_in = 1'b0; tick16(16'd0, a);
    checki("pre_rst_valid", int'(v16_out), 1);
    #2 rst = 1'b0;
    #1;
    checki("mid_rst_valid", int'(v16_out), 0);
    checkv("mid_rst_y", 400'(y16), 400'd0);
    checki("mid_rst_ready", int'(r16_out), 0);
    q16.delete();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    reset_counts();
    r16_in = 1'b1;
    x16 = 16'd2; v16_in = 1'b1; tick16(f16(x16), a);
    v16_in = 1'b0;
    for (int k = 0; k < 8; k++) tick16(16'd0, a);
    checki("post_rst_outputs", out16, 1);

    // Random soak on the 400-bit instance.
    accs = 0; outs = 0; sent = 0; budget = 0;
    while (sent < 1000 && budget < 20000) begin
      vs_in = ($urandom_range(0, 3) != 0);
      xs    = rand400();
      rs_in = $urandom_range(0, 1) == 1;
      tick400(a);
      if (a) sent++;
      budget++;
    end
    checki("soak_sent", sent, 1000);
    vs_in = 1'b0;
    rs_in = 1'b1;
    for (int k = 0; k < 30 && qs.size() > 0; k++) tick400(a);
    checki("soak_drain", qs.size(), 0);
    checki("soak_count", outs, accs);

    // Throughput: continuous input with the consumer always ready.
    accs = 0; outs = 0;
    for (int k = 0; k < 50; k++) begin
      vs_in = 1'b1;
      xs = rand400();
      tick400(a);
    end
    checki("thru_accepted", accs, 50);
    checki("thru_emitted", outs, 47);
    vs_in = 1'b0;
    for (int k = 0; k < 30 && qs.size() > 0; k++) tick400(a);
    checki("thru_drain", qs.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
